load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Parametrised data-memory access unit between the processor datapath and data main memory; replaces the tied-off dmem_stall path.
- Accepts one load/store request at a time and honours the memory ready handshake.
- Generates pipeline stall, byte enables, lane steering and sign/zero extension.
- Flags misaligned accesses and memory timeouts instead of silently corrupting state.

Parameters:
- XLEN, 32, data width in bits; legal values 32 or 64.
- ADDR_W, 16, byte-address width.
- TIMEOUT, 15, max WAIT cycles without mem_ready before abort; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  load/store request present this cycle
- req_wr  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64)
- req_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, right-aligned
- stall  out  1  hold pipeline
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  XLEN  extended load result; 0 for stores and errors
- misaligned  out  1  valid with resp_valid
- timeout_err  out  1  valid with resp_valid
- mem_en  out  1  memory access active
- mem_wr  out  1  memory write
- mem_addr  out  ADDR_W  lane-aligned address (low log2(XLEN/8) bits zero)
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_rdata  in  XLEN  memory read data
- mem_ready  in  1  access complete this cycle

Behaviour:
- OB = log2(XLEN/8). Offset = req_addr[OB-1:0].
- Misaligned when the offset is not a multiple of the access size in bytes, or when size=11 and XLEN=32.
- FSM states: IDLE, WAIT, RESP.
- Reset (async, rst=0): state IDLE; all outputs 0; timeout counter 0. Reset mid-WAIT or mid-RESP aborts the access with no response.
- IDLE:
  - stall = req_valid (combinational).
  - On req_valid and aligned: latch the request, go to WAIT.
  - On req_valid and misaligned: latch it, go to RESP with no memory access.
- WAIT:
  - mem_en=1 and mem_wr=latched req_wr.
  - mem_addr = latched address with offset bits cleared.
  - mem_be = size mask shifted left by offset (store or load).
  - mem_wdata = req_wdata shifted left by 8*offset.
  - stall=1; counter increments each cycle.
  - mem_ready=1: register the load lane (shift right by 8*offset, then sign- or zero-extend per req_size/req_unsigned) into resp_data; go to RESP.
  - TIMEOUT≠0 and counter reaches TIMEOUT with mem_ready=0: go to RESP with timeout_err=1 and resp_data=0.
  - mem_ready and the timeout in the same cycle: mem_ready wins.
- RESP:
  - Exactly one cycle; resp_valid=1, stall=0, mem_en=0; then go to IDLE.
  - req_valid during RESP is ignored, because the completing instruction is still presented.
  - misaligned and timeout_err are 1 only in RESP; 0 otherwise.
  - Stores return resp_data=0.
- Minimum load latency: accept in c0, ready in c1, resp_valid and data in c2. stall is high in c0–c1.
- Counter width is clog2(TIMEOUT+1) and saturates; it clears on entering WAIT.
- mem_* outputs are registered from latched state, with no combinational path from req_* inputs.

Test Plan:
- XLEN=32, load word addr 0x0010, mem_rdata=0xDEADBEEF, ready in first WAIT cycle -> stall c0–c1; resp_valid c2; resp_data=0xDEADBEEF; mem_be=1111; mem_addr=0x0010.
- Signed byte load addr 0x0013, mem_rdata=0x80FFFFFF -> resp_data=0xFFFFFF80. Same access with req_unsigned=1 -> 0x00000080.
- Half store addr 0x0006, wdata=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCD0000, mem_wr=1. resp_valid with resp_data=0.
- Half load addr 0x0005 -> no mem_en; resp_valid and misaligned=1 in c1; stall high in c0 only.
- TIMEOUT=4, mem_ready held low -> 4 WAIT cycles, then resp_valid and timeout_err=1. A second run with ready in the 4th cycle shows ready wins and timeout_err=0.
- Reset (rst=0) asserted mid-WAIT -> outputs 0 immediately, no resp_valid. XLEN=64 double load addr 0x0008 -> mem_be=0xFF.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory access unit: one outstanding load/store, lane steering, byte enables,
// sign/zero extension, misalignment and memory-timeout reporting.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              misaligned,
  output logic              timeout_err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [OB-1:0]     off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0]   resp_data_q, resp_data_d;
  logic              mis_q, mis_d;
  logic              tout_q, tout_d;
  logic              timeout_hit;

  function automatic logic misaligned_f(input logic [1:0] size, input logic [OB-1:0] off);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      2'b10:   return (off[1:0] != 2'b00);
      default: return (XLEN == 32) || (off != '0);
    endcase
  endfunction

  function automatic logic [NB-1:0] byte_en_f(input logic [1:0] size, input logic [OB-1:0] off);
    logic [NB-1:0] be;
    int nbytes;
    nbytes = int'(32'd1 << size);
    for (int i = 0; i < NB; i++) begin
      be[i] = (i >= int'(off)) && (i < int'(off) + nbytes);
    end
    return be;
  endfunction

  // Select the addressed lane, then fill the upper bits with the sign bit or zeros.
  function automatic logic [XLEN-1:0] load_ext_f(input logic [XLEN-1:0] rdata,
                                                 input logic [OB-1:0] off,
                                                 input logic [1:0] size,
                                                 input logic uns);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] mask;
    logic            sign;
    int              nbytes;
    sh     = rdata >> {off, 3'b000};
    nbytes = int'(32'd1 << size);
    for (int i = 0; i < NB; i++) begin
      mask[8*i +: 8] = (i < nbytes) ? 8'hFF : 8'h00;
    end
    case (size)
      2'b00:   sign = sh[7];
      2'b01:   sign = sh[15];
      2'b10:   sign = sh[31];
      default: sign = sh[XLEN-1];
    endcase
    return (sh & mask) | ((sign && !uns) ? ~mask : '0);
  endfunction

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // Next-state and latched-request logic.
  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    resp_data_d = resp_data_q;
    mis_d       = mis_q;
    tout_d      = tout_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          off_d  = req_addr[OB-1:0];
          size_d = req_size;
          uns_d  = req_unsigned;
          if (misaligned_f(req_size, req_addr[OB-1:0])) begin
            mis_d       = 1'b1;
            resp_data_d = '0;
            state_d     = S_RESP;
          end else begin
            mem_en_d    = 1'b1;
            mem_wr_d    = req_wr;
            mem_addr_d  = req_addr & ~ADDR_W'(NB - 1);
            mem_be_d    = byte_en_f(req_size, req_addr[OB-1:0]);
            mem_wdata_d = req_wdata << {req_addr[OB-1:0], 3'b000};
            cnt_d       = '0;
            state_d     = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
        // A ready arriving in the final allowed cycle still completes normally.
        if (mem_ready || timeout_hit) begin
          mem_en_d    = 1'b0;
          mem_wr_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = '0;
          mem_wdata_d = '0;
          state_d     = S_RESP;
          if (mem_ready) begin
            resp_data_d = mem_wr_q ? '0 : load_ext_f(mem_rdata, off_q, size_q, uns_q);
          end else begin
            tout_d      = 1'b1;
            resp_data_d = '0;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        mis_d       = 1'b0;
        tout_d      = 1'b0;
        resp_data_d = '0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      off_q       <= '0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      resp_data_q <= '0;
      mis_q       <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      resp_data_q <= resp_data_d;
      mis_q       <= mis_d;
      tout_q      <= tout_d;
    end
  end

  // stall must react to req_valid in the same cycle, so it stays combinational.
  assign stall       = rst && ((state_q == S_WAIT) || ((state_q == S_IDLE) && req_valid));
  assign resp_valid  = (state_q == S_RESP);
  assign resp_data   = resp_data_q;
  assign misaligned  = mis_q;
  assign timeout_err = tout_q;
  assign mem_en      = mem_en_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomised scoreboard bench for load_store_unit, exercising a 32-bit and a 64-bit instance.
module tb_load_store_unit;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        sel;
  logic        req_valid, req_wr, req_unsigned, mem_ready;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;
  logic        rv32, rv64;
  assign rv32 = req_valid & ~sel;
  assign rv64 = req_valid & sel;

  logic        stall32, rvld32, mis32, to32, en32, wr32;
  logic [31:0] rdata32, wd32;
  logic [15:0] addr32;
  logic [3:0]  be32;
  logic        stall64, rvld64, mis64, to64, en64, wr64;
  logic [63:0] rdata64, wd64;
  logic [15:0] addr64;
  logic [7:0]  be64;

  load_store_unit #(.XLEN(32), .ADDR_W(16), .TIMEOUT(TO)) dut32 (
    .clk(clk), .rst(rst), .req_valid(rv32), .req_wr(req_wr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .stall(stall32), .resp_valid(rvld32), .resp_data(rdata32), .misaligned(mis32),
    .timeout_err(to32), .mem_en(en32), .mem_wr(wr32), .mem_addr(addr32), .mem_be(be32),
    .mem_wdata(wd32), .mem_rdata(mem_rdata[31:0]), .mem_ready(mem_ready));

  load_store_unit #(.XLEN(64), .ADDR_W(16), .TIMEOUT(TO)) dut64 (
    .clk(clk), .rst(rst), .req_valid(rv64), .req_wr(req_wr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall64), .resp_valid(rvld64), .resp_data(rdata64), .misaligned(mis64),
    .timeout_err(to64), .mem_en(en64), .mem_wr(wr64), .mem_addr(addr64), .mem_be(be64),
    .mem_wdata(wd64), .mem_rdata(mem_rdata), .mem_ready(mem_ready));

  logic        o_stall, o_rvld, o_mis, o_to, o_en, o_wr;
  logic [63:0] o_rdata, o_wd;
  logic [15:0] o_addr;
  logic [7:0]  o_be;
  assign o_stall = sel ? stall64 : stall32;
  assign o_rvld  = sel ? rvld64  : rvld32;
  assign o_mis   = sel ? mis64   : mis32;
  assign o_to    = sel ? to64    : to32;
  assign o_en    = sel ? en64    : en32;
  assign o_wr    = sel ? wr64    : wr32;
  assign o_rdata = sel ? rdata64 : {32'd0, rdata32};
  assign o_wd    = sel ? wd64    : {32'd0, wd32};
  assign o_addr  = sel ? addr64  : addr32;
  assign o_be    = sel ? be64    : {4'd0, be32};

  typedef struct {
    logic [63:0] data;
    logic        mis;
    logic        tmo;
  } resp_t;
  resp_t exp_q[$];

  bit          exp_acc, exp_wr;
  logic [15:0] exp_addr;
  logic [7:0]  exp_be;
  logic [63:0] exp_wd, cur_rdata;
  int          cur_lat;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: computes the expected outcome from byte arithmetic, then drives one
  // request and checks the cycle-level handshake (stall / resp_valid timing).
  task automatic issue(input bit s, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [15:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                       input int lat, input bit junk, input int rst_after);
    int           xl, nb, off, n, nwait;
    bit           mis, tmo;
    logic [127:0] v, xmask;
    resp_t        r;
    xl    = s ? 64 : 32;
    nb    = xl / 8;
    off   = int'(addr) % nb;
    n     = 1 << sz;
    mis   = (off % n != 0) || (n > nb);
    tmo   = !mis && (lat > TO);
    xmask = (128'd1 << xl) - 128'd1;
    v     = ({64'd0, rd} >> (8 * off)) & ((128'd1 << (8 * n)) - 128'd1);
    if (!uns && v[8*n-1]) v = v - (128'd1 << (8 * n));
    r.data   = (mis || tmo || wr) ? 64'd0 : 64'(v & xmask);
    r.mis    = mis;
    r.tmo    = tmo;
    exp_acc  = !mis;
    exp_wr   = wr;
    exp_addr = addr - 16'(off);
    exp_be   = 8'(((1 << n) - 1) << off);
    exp_wd   = 64'((({64'd0, wd} & xmask) << (8 * off)) & xmask);
    cur_lat  = lat;
    cur_rdata = rd;
    nwait    = mis ? 0 : (tmo ? TO : lat);

    @(posedge clk); #1;
    sel = s; req_valid = 1'b1; req_wr = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    if (rst_after == 0) exp_q.push_back(r);
    @(negedge clk);
    chk("stall_accept", o_stall, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 16'($urandom); req_wdata = {$urandom, $urandom};

    if (rst_after > 0) begin
      repeat (rst_after) begin
        @(negedge clk);
        chk("stall_wait", o_stall, 64'd1);
      end
      rst = 1'b0;
      #1;
      chk("rst_stall", o_stall, 64'd0);
      chk("rst_mem_en", o_en, 64'd0);
      chk("rst_mem_be", o_be, 64'd0);
      chk("rst_mem_addr", o_addr, 64'd0);
      chk("rst_mem_wdata", o_wd, 64'd0);
      repeat (2) begin
        @(negedge clk);
        chk("rst_no_resp", o_rvld, 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_resp", o_rvld, 64'd0);
      return;
    end

    for (int k = 0; k < nwait; k++) begin
      @(negedge clk);
      chk("stall_wait", o_stall, 64'd1);
      chk("resp_early", o_rvld, 64'd0);
    end
    @(negedge clk);
    chk("resp_valid", o_rvld, 64'd1);
    chk("stall_resp", o_stall, 64'd0);
    chk("mem_en_resp", o_en, 64'd0);
    if (junk) begin
      req_valid = 1'b1; req_size = 2'($urandom); req_addr = 16'($urandom);
      #1;
      chk("stall_resp_req", o_stall, 64'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("resp_once", o_rvld, 64'd0);
    chk("idle_stall", o_stall, 64'd0);
  endtask

  // Monitor: pops the scoreboard on every response and checks each memory-access cycle.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (o_rvld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 64'd1, 64'd0);
        end else begin
          r = exp_q.pop_front();
          chk("resp_data", o_rdata, r.data);
          chk("misaligned", {63'd0, o_mis}, {63'd0, r.mis});
          chk("timeout_err", {63'd0, o_to}, {63'd0, r.tmo});
        end
      end else begin
        chk("flags_outside_resp", {62'd0, o_mis, o_to}, 64'd0);
      end
      if (o_en) begin
        chk("mem_access_allowed", 64'd1, {63'd0, exp_acc});
        chk("mem_wr", {63'd0, o_wr}, {63'd0, exp_wr});
        chk("mem_addr", {48'd0, o_addr}, {48'd0, exp_addr});
        chk("mem_be", {56'd0, o_be}, {56'd0, exp_be});
        chk("mem_wdata", o_wd, exp_wd);
      end
    end
  end

  // Memory responder: raises mem_ready in the cur_lat-th cycle of an access.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 64'd0;
    forever begin
      @(negedge clk);
      if (o_en) begin
        wcnt++;
        if (wcnt == cur_lat) begin
          mem_rdata = cur_rdata;
          mem_ready = 1'b1;
          @(posedge clk); #1;
          mem_ready = 1'b0;
          mem_rdata = {$urandom, $urandom};
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel = 1'b0; req_valid = 1'b1; req_wr = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 16'h0010; req_wdata = 64'd0;
    repeat (2) @(negedge clk);
    chk("reset_stall", o_stall, 64'd0);
    chk("reset_resp_valid", o_rvld, 64'd0);
    chk("reset_mem_en", o_en, 64'd0);
    chk("reset_resp_data", o_rdata, 64'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    issue(1'b0, 1'b0, 2'b10, 1'b0, 16'h0010, 64'd0, 64'h00000000DEADBEEF, 1, 1'b0, 0);
    issue(1'b0, 1'b0, 2'b00, 1'b0, 16'h0013, 64'd0, 64'h0000000080FFFFFF, 1, 1'b0, 0);
    issue(1'b0, 1'b0, 2'b00, 1'b1, 16'h0013, 64'd0, 64'h0000000080FFFFFF, 2, 1'b0, 0);
    issue(1'b0, 1'b1, 2'b01, 1'b0, 16'h0006, 64'h000000000000ABCD, 64'h1234567812345678, 1, 1'b0, 0);
    issue(1'b0, 1'b0, 2'b01, 1'b0, 16'h0005, 64'd0, 64'd0, 1, 1'b0, 0);
    issue(1'b0, 1'b0, 2'b10, 1'b0, 16'h0020, 64'd0, 64'h00000000CAFEF00D, 100, 1'b0, 0);
    issue(1'b0, 1'b0, 2'b10, 1'b0, 16'h0020, 64'd0, 64'h00000000CAFEF00D, TO, 1'b1, 0);
    issue(1'b0, 1'b0, 2'b10, 1'b0, 16'h0030, 64'd0, 64'd0, 100, 1'b0, 2);
    issue(1'b0, 1'b0, 2'b11, 1'b0, 16'h0008, 64'd0, 64'd0, 1, 1'b0, 0);
    issue(1'b1, 1'b0, 2'b11, 1'b0, 16'h0008, 64'd0, 64'h8877665544332211, 1, 1'b0, 0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 16'h000C, 64'd0, 64'h89ABCDEF00000000, 3, 1'b0, 0);

    for (int t = 0; t < 160; t++) begin
      issue(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 16'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(1, 6)),
            1'($urandom), 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
